// File: rtl/sys_ctrl_if.sv
// Bus bundle between the command controller and its surroundings: UART
// receive side, register file, ALU and the TX FIFO write port.
interface sys_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int OP_WIDTH   = 4
);
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_valid;
  logic                    rf_wr_en;
  logic                    rf_rd_en;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_rd_valid;
  logic                    alu_en;
  logic [OP_WIDTH-1:0]     alu_fun;
  logic                    alu_clk_en;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_out_valid;
  logic [DATA_WIDTH-1:0]   fifo_wr_data;
  logic                    fifo_wr_en;
  logic                    fifo_full;
  logic                    busy;

  // Controller side
  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, fifo_full,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, alu_clk_en,
           fifo_wr_data, fifo_wr_en, busy
  );

  // Environment side (UART RX, register file, ALU, TX FIFO)
  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, fifo_full,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, alu_clk_en,
           fifo_wr_data, fifo_wr_en, busy
  );
endinterface

// File: rtl/sys_ctrl.sv
// Command-decoding controller: turns received UART byte frames into register
// file accesses and ALU operations, and pushes result bytes into the TX FIFO.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  sys_ctrl_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_OPA, ALU_OPB,
    ALU_FUN, ALU_WAIT, PUSH_LO, PUSH_HI
  } state_t;

  state_t                  state_reg;
  logic                    rf_wr_en_reg;
  logic                    rf_rd_en_reg;
  logic [ADDR_WIDTH-1:0]   rf_addr_reg;
  logic [DATA_WIDTH-1:0]   rf_wr_data_reg;
  logic                    alu_en_reg;
  logic [OP_WIDTH-1:0]     alu_fun_reg;
  logic                    alu_clk_en_reg;
  logic [DATA_WIDTH-1:0]   fifo_wr_data_reg;
  logic                    fifo_wr_en_reg;
  logic                    busy_reg;
  logic [DATA_WIDTH-1:0]   result_hi_reg;   // upper ALU byte waiting for its push
  logic                    ret_alu_reg;     // current result has two bytes

  // Command FSM; every output is a register updated here.
  // A push "fires" in a cycle where fifo_wr_en is high; the enable is only
  // raised when fifo_full was low on the preceding edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      rf_wr_en_reg     <= 1'b0;
      rf_rd_en_reg     <= 1'b0;
      rf_addr_reg      <= '0;
      rf_wr_data_reg   <= '0;
      alu_en_reg       <= 1'b0;
      alu_fun_reg      <= '0;
      alu_clk_en_reg   <= 1'b0;
      fifo_wr_data_reg <= '0;
      fifo_wr_en_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      result_hi_reg    <= '0;
      ret_alu_reg      <= 1'b0;
    end else begin
      rf_wr_en_reg   <= 1'b0;
      rf_rd_en_reg   <= 1'b0;
      alu_en_reg     <= 1'b0;
      fifo_wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.rx_valid) begin
            case (bus.rx_data)
              CMD_WR:  begin state_reg <= WR_ADDR; busy_reg <= 1'b1; end
              CMD_RD:  begin state_reg <= RD_ADDR; busy_reg <= 1'b1; end
              CMD_ALU: begin state_reg <= ALU_OPA; busy_reg <= 1'b1; end
              CMD_FUN: begin state_reg <= ALU_FUN; busy_reg <= 1'b1; end
              default: ;  // unknown command byte is dropped
            endcase
          end
        end
        WR_ADDR: begin
          if (bus.rx_valid) begin
            rf_addr_reg <= bus.rx_data[ADDR_WIDTH-1:0];
            state_reg   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (bus.rx_valid) begin
            rf_wr_en_reg   <= 1'b1;
            rf_wr_data_reg <= bus.rx_data;
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (bus.rx_valid) begin
            rf_rd_en_reg <= 1'b1;
            rf_addr_reg  <= bus.rx_data[ADDR_WIDTH-1:0];
            ret_alu_reg  <= 1'b0;
            state_reg    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.rf_rd_valid) begin
            fifo_wr_data_reg <= bus.rf_rd_data;
            fifo_wr_en_reg   <= ~bus.fifo_full;
            state_reg        <= PUSH_LO;
          end
        end
        ALU_OPA: begin
          if (bus.rx_valid) begin
            rf_wr_en_reg   <= 1'b1;
            rf_addr_reg    <= ADDR_WIDTH'(0);
            rf_wr_data_reg <= bus.rx_data;
            state_reg      <= ALU_OPB;
          end
        end
        ALU_OPB: begin
          if (bus.rx_valid) begin
            rf_wr_en_reg   <= 1'b1;
            rf_addr_reg    <= ADDR_WIDTH'(1);
            rf_wr_data_reg <= bus.rx_data;
            state_reg      <= ALU_FUN;
          end
        end
        ALU_FUN: begin
          if (bus.rx_valid) begin
            alu_en_reg     <= 1'b1;
            alu_clk_en_reg <= 1'b1;
            alu_fun_reg    <= bus.rx_data[OP_WIDTH-1:0];
            ret_alu_reg    <= 1'b1;
            state_reg      <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (bus.alu_out_valid) begin
            alu_clk_en_reg   <= 1'b0;
            fifo_wr_data_reg <= bus.alu_out[DATA_WIDTH-1:0];
            result_hi_reg    <= bus.alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
            fifo_wr_en_reg   <= ~bus.fifo_full;
            state_reg        <= PUSH_LO;
          end
        end
        PUSH_LO: begin
          if (fifo_wr_en_reg) begin
            if (ret_alu_reg) begin
              fifo_wr_data_reg <= result_hi_reg;
              fifo_wr_en_reg   <= ~bus.fifo_full;
              state_reg        <= PUSH_HI;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            fifo_wr_en_reg <= ~bus.fifo_full;
          end
        end
        PUSH_HI: begin
          if (fifo_wr_en_reg) begin
            alu_fun_reg <= '0;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end else begin
            fifo_wr_en_reg <= ~bus.fifo_full;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_wr_en     = rf_wr_en_reg;
  assign bus.rf_rd_en     = rf_rd_en_reg;
  assign bus.rf_addr      = rf_addr_reg;
  assign bus.rf_wr_data   = rf_wr_data_reg;
  assign bus.alu_en       = alu_en_reg;
  assign bus.alu_fun      = alu_fun_reg;
  assign bus.alu_clk_en   = alu_clk_en_reg;
  assign bus.fifo_wr_data = fifo_wr_data_reg;
  assign bus.fifo_wr_en   = fifo_wr_en_reg;
  assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: directed byte frames, a small register-file
// and ALU model, and a monitor that checks every strobe against queued
// expectations.
module tb_sys_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) bus ();

  sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int failed    = 0;

  logic [7:0]  exp_fifo[$];
  logic [11:0] exp_wr[$];   // {addr, data}
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];

  // Environment models
  logic [7:0]  mem [16] = '{default: 8'h00};
  logic [7:0]  rd_data_m  = 8'h00;
  logic        rd_valid_m = 1'b0;
  logic [15:0] alu_res_m  = 16'h0000;
  logic        alu_vld_m  = 1'b0;
  int          alu_cnt    = 0;
  int          alu_lat    = 3;

  assign bus.rf_rd_data    = rd_data_m;
  assign bus.rf_rd_valid   = rd_valid_m;
  assign bus.alu_out       = alu_res_m;
  assign bus.alu_out_valid = alu_vld_m;

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] fun);
    case (fun)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {8'h00, a} * {8'h00, b};
      default: return {a, b};
    endcase
  endfunction

  // Register file model: one-cycle read latency
  always @(posedge clk) begin
    rd_valid_m <= 1'b0;
    if (!rst) begin
      if (bus.rf_wr_en) mem[bus.rf_addr] <= bus.rf_wr_data;
      if (bus.rf_rd_en) begin
        rd_data_m  <= mem[bus.rf_addr];
        rd_valid_m <= 1'b1;
      end
    end
  end

  // ALU model: result valid alu_lat cycles after the alu_en cycle
  always @(posedge clk) begin
    alu_vld_m <= 1'b0;
    if (rst) begin
      alu_cnt <= 0;
    end else if (bus.alu_en) begin
      alu_cnt   <= alu_lat;
      alu_res_m <= alu_model(mem[0], mem[1], bus.alu_fun);
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 2) alu_vld_m <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests_run++;
    failed++;
    $display("FAIL %s: got 0x%0h, required no strobe", name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_wr_en) begin
        $display("[TB] fifo push 0x%02h", bus.fifo_wr_data);
        check("push_while_full", {31'd0, bus.fifo_full}, 32'd0);
        if (exp_fifo.size() == 0) unexpected("fifo_push", {24'd0, bus.fifo_wr_data});
        else check("fifo_data", {24'd0, bus.fifo_wr_data}, {24'd0, exp_fifo.pop_front()});
      end
      if (bus.rf_wr_en) begin
        $display("[TB] rf write addr %0d data 0x%02h", bus.rf_addr, bus.rf_wr_data);
        if (exp_wr.size() == 0) unexpected("rf_write", {20'd0, bus.rf_addr, bus.rf_wr_data});
        else check("rf_write", {20'd0, bus.rf_addr, bus.rf_wr_data}, {20'd0, exp_wr.pop_front()});
      end
      if (bus.rf_rd_en) begin
        $display("[TB] rf read addr %0d", bus.rf_addr);
        if (exp_rd.size() == 0) unexpected("rf_read", {28'd0, bus.rf_addr});
        else check("rf_read_addr", {28'd0, bus.rf_addr}, {28'd0, exp_rd.pop_front()});
      end
      if (bus.alu_en) begin
        $display("[TB] alu start fun %0d", bus.alu_fun);
        check("alu_en_clk_en", {31'd0, bus.alu_clk_en}, 32'd1);
        if (exp_alu.size() == 0) unexpected("alu_start", {28'd0, bus.alu_fun});
        else check("alu_fun", {28'd0, bus.alu_fun}, {28'd0, exp_alu.pop_front()});
      end
      if (bus.fifo_wr_en || bus.rf_wr_en || bus.rf_rd_en || bus.alu_en)
        check("strobe_exclusive",
              32'(bus.fifo_wr_en) + 32'(bus.rf_wr_en) + 32'(bus.rf_rd_en) + 32'(bus.alu_en), 32'd1);
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    $display("[TB] rx byte 0x%02h", b);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rf_wr_en"},     {31'd0, bus.rf_wr_en},     32'd0);
    check({tag, "_rf_rd_en"},     {31'd0, bus.rf_rd_en},     32'd0);
    check({tag, "_rf_addr"},      {28'd0, bus.rf_addr},      32'd0);
    check({tag, "_rf_wr_data"},   {24'd0, bus.rf_wr_data},   32'd0);
    check({tag, "_alu_en"},       {31'd0, bus.alu_en},       32'd0);
    check({tag, "_alu_fun"},      {28'd0, bus.alu_fun},      32'd0);
    check({tag, "_alu_clk_en"},   {31'd0, bus.alu_clk_en},   32'd0);
    check({tag, "_fifo_wr_data"}, {24'd0, bus.fifo_wr_data}, 32'd0);
    check({tag, "_fifo_wr_en"},   {31'd0, bus.fifo_wr_en},   32'd0);
    check({tag, "_busy"},         {31'd0, bus.busy},         32'd0);
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.fifo_full = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write AA,05,3C
    exp_wr.push_back({4'h5, 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C);
    wait_idle("write_idle");

    // Read BB,05 -> push 0x3C
    exp_rd.push_back(4'h5);
    exp_fifo.push_back(8'h3C);
    send(8'hBB); send(8'h05);
    wait_idle("read_idle");

    // CC,12,34,00: RF[0]=12, RF[1]=34, add -> 0x0046
    exp_wr.push_back({4'h0, 8'h12});
    exp_wr.push_back({4'h1, 8'h34});
    exp_alu.push_back(4'h0);
    exp_fifo.push_back(8'h46);
    exp_fifo.push_back(8'h00);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
    wait_idle("alu_cc_idle");

    // Back-pressure: DD,02 mul 0x12*0x34 = 0x03A8 while FIFO full
    bus.fifo_full = 1'b1;
    exp_alu.push_back(4'h2);
    exp_fifo.push_back(8'hA8);
    exp_fifo.push_back(8'h03);
    send(8'hDD); send(8'h02);
    n = 0;
    @(negedge clk);
    while (!bus.alu_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_result_seen", {31'd0, bus.alu_out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_data", {24'd0, bus.fifo_wr_data}, 32'h0000_00A8);
      check("bp_no_push",   {31'd0, bus.fifo_wr_en},   32'd0);
    end
    @(posedge clk);
    #1;
    bus.fifo_full = 1'b0;
    wait_idle("bp_idle");

    // alu_clk_en window: DD,01 sub 0x12-0x34 = 0xFFDE, latency 3
    alu_lat = 3;
    exp_alu.push_back(4'h1);
    exp_fifo.push_back(8'hDE);
    exp_fifo.push_back(8'hFF);
    @(negedge clk);
    check("clk_en_before", {31'd0, bus.alu_clk_en}, 32'd0);
    @(posedge clk);
    #1;
    send(8'hDD); send(8'h01);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("clk_en_window", {31'd0, bus.alu_clk_en}, (i <= 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    wait_idle("clk_en_idle");

    // Unknown command byte
    send(8'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("unknown_busy", {31'd0, bus.busy}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset mid-frame, then a fresh write to addr 6
    send(8'hAA); send(8'h05);
    @(negedge clk);
    check("midframe_busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_wr.push_back({4'h6, 8'hFF});
    send(8'hAA); send(8'h06); send(8'hFF);
    wait_idle("post_rst_idle");

    // Everything expected must have been observed
    repeat (3) @(negedge clk);
    check("left_fifo", exp_fifo.size(), 32'd0);
    check("left_wr",   exp_wr.size(),   32'd0);
    check("left_rd",   exp_rd.size(),   32'd0);
    check("left_alu",  exp_alu.size(),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
